// File: rtl/koopa_sprite_renderer_if.sv
// Raster-in / pixel-out / sprite-sheet ROM bundle for koopa_sprite_renderer.
//   master : video timing + ROM side (drives raster, rom_data; receives pixels, rom_addr)
//   slave  : the renderer
// Signals:
//   pixel_valid, hcount, vcount : raster position for this cycle
//   rom_addr, rom_data          : synchronous sheet ROM, 1-cycle read latency
//   pix_valid, pix_index, pix_opaque : rendered pixel towards the layer mixer
interface koopa_sprite_renderer_if #(
    parameter int ADDR_W = 15
) ();
    logic              pixel_valid;
    logic [9:0]        hcount;
    logic [9:0]        vcount;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              pix_valid;
    logic [7:0]        pix_index;
    logic              pix_opaque;

    modport master (
        output pixel_valid, hcount, vcount, rom_data,
        input  rom_addr, pix_valid, pix_index, pix_opaque
    );

    modport slave (
        input  pixel_valid, hcount, vcount, rom_data,
        output rom_addr, pix_valid, pix_index, pix_opaque
    );
endinterface

// File: rtl/koopa_sprite_renderer.sv
// Koopa sprite renderer: maps the raster position onto a sprite-sheet ROM
// address and returns palette pixels with key-colour transparency. Animation
// cell and screen position are latched into shadow registers on frame_start
// so a sprite never changes mid-frame.
// Ports:
//   clk, reset (sync, active-high)
//   frame_start           : one-cycle pulse at start of vertical blank
//   anim_row, anim_col    : sheet cell in GRID_PX units
//   sprite_x, sprite_y    : screen top-left of the sprite
//   facing_left           : horizontal mirror
//   cfg_err               : sticky, set when a frame latch is rejected
//   bus (slave)           : raster in, ROM address/data, pixel out
//
// state    | meaning
// ---------+--------------------------------------------------------------
// NO_FRAME | no shadow loaded; pixels flow through but are never opaque
// ACTIVE   | shadow loaded; pixels rendered from the shadow registers
module koopa_sprite_renderer #(
    parameter int         GRID_PX   = 4,
    parameter int         SPR_W     = 32,
    parameter int         SPR_H     = 32,
    parameter int         SHEET_W   = 256,
    parameter int         SHEET_H   = 128,
    parameter int         ADDR_W    = 15,
    parameter logic [7:0] KEY_COLOR = 8'hE3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic [5:0] anim_row,
    input  logic [5:0] anim_col,
    input  logic [9:0] sprite_x,
    input  logic [9:0] sprite_y,
    input  logic       facing_left,
    output logic       cfg_err,
    koopa_sprite_renderer_if.slave bus
);

    typedef enum logic {NO_FRAME, ACTIVE} state_t;

    state_t     state;
    logic [5:0] shadow_row;
    logic [5:0] shadow_col;
    logic [9:0] shadow_x;
    logic [9:0] shadow_y;
    logic       shadow_flip;

    logic v1, inbox1, v2, inbox2;

    logic [11:0]       col_end, row_end;
    logic              bounds_ok;
    logic [10:0]       dx, dy, dxe;
    logic              inbox;
    logic [ADDR_W-1:0] addr_next;
    logic              opaque_next;

    always_comb begin
        col_end   = 12'(anim_col) * 12'(GRID_PX) + 12'(SPR_W);
        row_end   = 12'(anim_row) * 12'(GRID_PX) + 12'(SPR_H);
        bounds_ok = (col_end <= 12'(SHEET_W)) && (row_end <= 12'(SHEET_H));

        // 11-bit differences: bit 10 is the sign, so a sprite hanging off the
        // right/bottom edge can never alias onto the left/top of the screen.
        dx    = {1'b0, bus.hcount} - {1'b0, shadow_x};
        dy    = {1'b0, bus.vcount} - {1'b0, shadow_y};
        inbox = (state == ACTIVE) && !dx[10] && (dx < 11'(SPR_W))
                                  && !dy[10] && (dy < 11'(SPR_H));
        dxe   = shadow_flip ? (11'(SPR_W - 1) - dx) : dx;

        addr_next = ADDR_W'((32'(shadow_row) * GRID_PX + 32'(dy)) * SHEET_W
                            + 32'(shadow_col) * GRID_PX + 32'(dxe));

        opaque_next = v2 && inbox2 && (bus.rom_data != KEY_COLOR);
    end

    // Shadow update and stage 1 share an edge, so a pixel sampled together
    // with frame_start still sees the old shadow.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= NO_FRAME;
            shadow_row     <= '0;
            shadow_col     <= '0;
            shadow_x       <= '0;
            shadow_y       <= '0;
            shadow_flip    <= 1'b0;
            cfg_err        <= 1'b0;
            v1             <= 1'b0;
            inbox1         <= 1'b0;
            v2             <= 1'b0;
            inbox2         <= 1'b0;
            bus.rom_addr   <= '0;
            bus.pix_valid  <= 1'b0;
            bus.pix_opaque <= 1'b0;
            bus.pix_index  <= '0;
        end else begin
            if (frame_start) begin
                if (bounds_ok) begin
                    state       <= ACTIVE;
                    shadow_row  <= anim_row;
                    shadow_col  <= anim_col;
                    shadow_x    <= sprite_x;
                    shadow_y    <= sprite_y;
                    shadow_flip <= facing_left;
                end else begin
                    cfg_err <= 1'b1;
                end
            end

            v1     <= bus.pixel_valid;
            inbox1 <= inbox;
            if (inbox)
                bus.rom_addr <= addr_next;

            v2     <= v1;
            inbox2 <= inbox1;

            bus.pix_valid  <= v2;
            bus.pix_opaque <= opaque_next;
            bus.pix_index  <= opaque_next ? bus.rom_data : 8'h00;
        end
    end

endmodule
